// File: rtl/ppc_types.sv
// Shared types for the PowerPC-style out-of-order core slice.
//   RS_ID_WIDTH  : width of reservation-station tags (matches the CR file)
//   cr_op_t      : CR-logical operation selector
//   cr_operand_t : one CR-field operand slot (valid flag, producer tag, 4-bit value)
package ppc_types;

    localparam int RS_ID_WIDTH = 5;

    typedef enum logic [2:0] {
        CR_AND  = 3'd0,
        CR_OR   = 3'd1,
        CR_XOR  = 3'd2,
        CR_NAND = 3'd3,
        CR_NOR  = 3'd4,
        CR_EQV  = 3'd5,
        CR_ANDC = 3'd6,
        CR_ORC  = 3'd7
    } cr_op_t;

    // value is big-endian: value[0] is the LT bit of the field.
    typedef struct packed {
        logic                   valid;
        logic [RS_ID_WIDTH-1:0] rs_id;
        logic [0:3]             value;
    } cr_operand_t;

endpackage

// File: rtl/cr_logical_alu.sv
// Combinational CR-logical datapath.
//   op           : logical operation
//   opnd_a/b     : CR fields holding the source bits
//   opnd_t       : old contents of the destination field
//   pos_a/b/t    : bit position (0..3, big-endian) within each field
//   result       : opnd_t with bit pos_t replaced by op(a, b)
module cr_logical_alu
    import ppc_types::*;
(
    input  cr_op_t     op,
    input  logic [0:3] opnd_a,
    input  logic [0:3] opnd_b,
    input  logic [0:3] opnd_t,
    input  logic [1:0] pos_a,
    input  logic [1:0] pos_b,
    input  logic [1:0] pos_t,
    output logic [0:3] result
);

    logic a;
    logic b;
    logic r;

    always_comb begin
        a = opnd_a[pos_a];
        b = opnd_b[pos_b];
        r = 1'b0;
        case (op)
            CR_AND:  r = a & b;
            CR_OR:   r = a | b;
            CR_XOR:  r = a ^ b;
            CR_NAND: r = ~(a & b);
            CR_NOR:  r = ~(a | b);
            CR_EQV:  r = ~(a ^ b);
            CR_ANDC: r = a & ~b;
            CR_ORC:  r = a | ~b;
            default: r = 1'b0;
        endcase
        result        = opnd_t;
        result[pos_t] = r;
    end

endmodule

// File: rtl/cr_logical_rs.sv
// Reservation station + execution unit for CR-logical instructions.
//   clk, rst              : clock, synchronous active-high reset
//   dispatch_*            : instruction offer (valid/ready, op, CR bit indices)
//   cr_value_valid/value/rs_id : CR file read port (state before this dispatch)
//   update_enable/rs_id   : CR file update port, claims the destination field
//   cdb_*                 : CR result broadcast snooped for pending operands
//   result_*              : finished destination field, valid/ready handshake
module cr_logical_rs
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int RS_OFFSET   = 0,
    parameter int NUM_ENTRIES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dispatch_valid,
    output logic                         dispatch_ready,
    input  cr_op_t                       dispatch_op,
    input  logic [0:4]                   dispatch_ba,
    input  logic [0:4]                   dispatch_bb,
    input  logic [0:4]                   dispatch_bt,
    input  logic [0:7]                   cr_value_valid,
    input  logic [0:31]                  cr_value,
    input  logic [0:7][RS_ID_WIDTH-1:0]  cr_rs_id,
    output logic [0:7]                   update_enable,
    output logic [0:7][RS_ID_WIDTH-1:0]  update_rs_id,
    input  logic                         cdb_valid,
    input  logic [RS_ID_WIDTH-1:0]       cdb_rs_id,
    input  logic [0:3]                   cdb_value,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [RS_ID_WIDTH-1:0]       result_rs_id,
    output logic [0:2]                   result_field,
    output logic [0:3]                   result_value
);

    localparam int IdxW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    // opnd[0] = A (field of ba), opnd[1] = B (field of bb), opnd[2] = T (old field of bt)
    typedef struct packed {
        cr_op_t                 op;
        logic [1:0]             pos_a;
        logic [1:0]             pos_b;
        logic [1:0]             pos_t;
        logic [2:0]             field_t;
        cr_operand_t [2:0]      opnd;
    } entry_t;

    function automatic logic [RS_ID_WIDTH-1:0] tag_of(input logic [IdxW-1:0] idx);
        return RS_ID_WIDTH'(RS_OFFSET + int'(idx));
    endfunction

    logic [NUM_ENTRIES-1:0] busy_q, busy_d;
    entry_t                 entry_q [NUM_ENTRIES];
    entry_t                 entry_d [NUM_ENTRIES];
    logic                   lock_q, lock_d;
    logic [IdxW-1:0]        lock_idx_q, lock_idx_d;

    logic                   alloc_found;
    logic [IdxW-1:0]        alloc_idx;
    logic                   rdy_found;
    logic [IdxW-1:0]        rdy_idx;
    logic [IdxW-1:0]        sel_idx;
    logic                   fire;
    logic [2:0]             fld [3];
    entry_t                 new_entry;
    entry_t                 sel_entry;

    // Free-entry allocation and ready-entry selection, both lowest index first.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        rdy_found   = 1'b0;
        rdy_idx     = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            if (!busy_q[k] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = IdxW'(k);
            end
            if (busy_q[k] && !rdy_found && entry_q[k].opnd[0].valid &&
                entry_q[k].opnd[1].valid && entry_q[k].opnd[2].valid) begin
                rdy_found = 1'b1;
                rdy_idx   = IdxW'(k);
            end
        end
    end

    // A presented-but-unaccepted result pins the selection so a lower entry
    // becoming ready cannot change the outputs mid-handshake.
    assign sel_idx        = lock_q ? lock_idx_q : rdy_idx;
    assign sel_entry      = entry_q[sel_idx];
    assign result_valid   = lock_q | rdy_found;
    assign result_rs_id   = tag_of(sel_idx);
    assign result_field   = sel_entry.field_t;
    assign dispatch_ready = alloc_found;
    assign fire           = dispatch_valid && alloc_found && !rst;

    // Build the entry being dispatched from the pre-update CR file state.
    always_comb begin
        fld[0] = dispatch_ba[0:2];
        fld[1] = dispatch_bb[0:2];
        fld[2] = dispatch_bt[0:2];
        new_entry         = '0;
        new_entry.op      = dispatch_op;
        new_entry.pos_a   = dispatch_ba[3:4];
        new_entry.pos_b   = dispatch_bb[3:4];
        new_entry.pos_t   = dispatch_bt[3:4];
        new_entry.field_t = dispatch_bt[0:2];
        for (int j = 0; j < 3; j++) begin
            new_entry.opnd[j].rs_id = cr_rs_id[fld[j]];
            if (cr_value_valid[fld[j]]) begin
                new_entry.opnd[j].valid = 1'b1;
                new_entry.opnd[j].value = cr_value[{fld[j], 2'b00} +: 4];
            end else if (cdb_valid && (cr_rs_id[fld[j]] == cdb_rs_id)) begin
                // Producer is broadcasting this very cycle: forward it.
                new_entry.opnd[j].valid = 1'b1;
                new_entry.opnd[j].value = cdb_value;
            end
        end
    end

    always_comb begin
        update_enable = '0;
        update_rs_id  = '0;
        if (fire) begin
            update_enable[dispatch_bt[0:2]] = 1'b1;
            update_rs_id[dispatch_bt[0:2]]  = tag_of(alloc_idx);
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            entry_d[k] = entry_q[k];
            for (int j = 0; j < 3; j++) begin
                if (busy_q[k] && !entry_q[k].opnd[j].valid && cdb_valid &&
                    (entry_q[k].opnd[j].rs_id == cdb_rs_id)) begin
                    entry_d[k].opnd[j].valid = 1'b1;
                    entry_d[k].opnd[j].value = cdb_value;
                end
            end
        end
        if (result_valid && result_ready) begin
            busy_d[sel_idx] = 1'b0;
        end
        // alloc_idx is a free entry, so it never collides with the one retiring.
        if (fire) begin
            busy_d[alloc_idx]  = 1'b1;
            entry_d[alloc_idx] = new_entry;
        end
        lock_d     = result_valid && !result_ready;
        lock_idx_d = sel_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                entry_q[k] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                entry_q[k] <= entry_d[k];
            end
        end
    end

    cr_logical_alu u_alu (
        .op     (sel_entry.op),
        .opnd_a (sel_entry.opnd[0].value),
        .opnd_b (sel_entry.opnd[1].value),
        .opnd_t (sel_entry.opnd[2].value),
        .pos_a  (sel_entry.pos_a),
        .pos_b  (sel_entry.pos_b),
        .pos_t  (sel_entry.pos_t),
        .result (result_value)
    );

endmodule

// File: tb/tb_cr_logical_rs.sv
// Directed self-checking bench for cr_logical_rs (default parameters).
module tb_cr_logical_rs;
    import ppc_types::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             dispatch_valid;
    logic             dispatch_ready;
    cr_op_t           dispatch_op;
    logic [0:4]       dispatch_ba;
    logic [0:4]       dispatch_bb;
    logic [0:4]       dispatch_bt;
    logic [0:7]       cr_value_valid;
    logic [0:31]      cr_value;
    logic [0:7][4:0]  cr_rs_id;
    logic [0:7]       update_enable;
    logic [0:7][4:0]  update_rs_id;
    logic             cdb_valid;
    logic [4:0]       cdb_rs_id;
    logic [0:3]       cdb_value;
    logic             result_valid;
    logic             result_ready;
    logic [4:0]       result_rs_id;
    logic [0:2]       result_field;
    logic [0:3]       result_value;

    int n_chk  = 0;
    int n_fail = 0;

    // a = CR bit 8 = 1, b = CR bit 12 = 0, T = field 5 = 0000, target bit 20 (field 5 pos 0)
    cr_op_t     ops  [8] = '{CR_AND, CR_OR, CR_XOR, CR_NAND, CR_NOR, CR_EQV, CR_ANDC, CR_ORC};
    logic [3:0] exp8 [8] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000,
                             4'b0000, 4'b0000, 4'b1000, 4'b1000};

    always #5 clk = ~clk;

    cr_logical_rs dut (
        .clk            (clk),
        .rst            (rst),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .dispatch_op    (dispatch_op),
        .dispatch_ba    (dispatch_ba),
        .dispatch_bb    (dispatch_bb),
        .dispatch_bt    (dispatch_bt),
        .cr_value_valid (cr_value_valid),
        .cr_value       (cr_value),
        .cr_rs_id       (cr_rs_id),
        .update_enable  (update_enable),
        .update_rs_id   (update_rs_id),
        .cdb_valid      (cdb_valid),
        .cdb_rs_id      (cdb_rs_id),
        .cdb_value      (cdb_value),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_rs_id   (result_rs_id),
        .result_field   (result_field),
        .result_value   (result_value)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input cr_op_t op, input logic [0:4] ba, input logic [0:4] bb,
                        input logic [0:4] bt);
        dispatch_valid = 1'b1;
        dispatch_op    = op;
        dispatch_ba    = ba;
        dispatch_bb    = bb;
        dispatch_bt    = bt;
    endtask

    task automatic chk_res(input string tag, input logic [4:0] id, input logic [2:0] f,
                           input logic [3:0] v);
        chk({tag, ".valid"}, 32'(result_valid), 32'd1);
        chk({tag, ".rs_id"}, 32'(result_rs_id), 32'(id));
        chk({tag, ".field"}, 32'(result_field), 32'(f));
        chk({tag, ".value"}, 32'(result_value), 32'(v));
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        dispatch_valid = 1'b0;
        dispatch_op    = CR_AND;
        dispatch_ba    = '0;
        dispatch_bb    = '0;
        dispatch_bt    = '0;
        cr_value_valid = '1;
        cr_value       = '0;
        cr_rs_id       = '0;
        cdb_valid      = 1'b0;
        cdb_rs_id      = '0;
        cdb_value      = '0;
        result_ready   = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset.result_valid", 32'(result_valid), 32'd0);
        chk("reset.dispatch_ready", 32'(dispatch_ready), 32'd1);
        chk("reset.update_enable", 32'(update_enable), 32'd0);
        chk("reset.update_rs_id", 32'(update_rs_id), 32'd0);

        // crand ba=0 bb=1 bt=2 with CR = C000_0000
        cr_value = 32'hC000_0000;
        disp(CR_AND, 5'd0, 5'd1, 5'd2);
        #1;
        chk("crand.update_enable", 32'(update_enable), 32'h80);
        chk("crand.update_rs_id0", 32'(update_rs_id[0]), 32'd0);
        chk("crand.early_valid", 32'(result_valid), 32'd0);
        step();
        dispatch_valid = 1'b0;
        #1;
        chk_res("crand", 5'd0, 3'd0, 4'b1110);
        handshake();
        #1;
        chk("crand.after_hs", 32'(result_valid), 32'd0);

        // cror ba=4 bb=8 bt=12, field 1 pending on tag 7
        cr_value       = 32'h0000_0000;
        cr_value_valid = 8'b1011_1111;
        cr_rs_id[1]    = 5'd7;
        disp(CR_OR, 5'd4, 5'd8, 5'd12);
        #1;
        chk("cror.update_enable", 32'(update_enable), 32'h10);
        step();
        dispatch_valid = 1'b0;
        cr_value_valid = '1;
        cdb_valid      = 1'b1;
        cdb_rs_id      = 5'd8;
        cdb_value      = 4'b1111;
        #1;
        chk("cror.waiting", 32'(result_valid), 32'd0);
        step();
        cdb_rs_id = 5'd7;
        cdb_value = 4'b0000;
        #1;
        chk("cror.wrong_tag", 32'(result_valid), 32'd0);
        step();
        cdb_valid = 1'b0;
        #1;
        chk_res("cror", 5'd0, 3'd3, 4'b0000);
        handshake();

        // crxor ba=4 bb=5 bt=6, field 1 forwarded from the CDB in the dispatch cycle
        cr_value       = 32'h0F00_0000;
        cr_value_valid = 8'b1011_1111;
        cr_rs_id[1]    = 5'd9;
        cdb_valid      = 1'b1;
        cdb_rs_id      = 5'd9;
        cdb_value      = 4'b1000;
        disp(CR_XOR, 5'd4, 5'd5, 5'd6);
        step();
        dispatch_valid = 1'b0;
        cdb_valid      = 1'b0;
        cr_value_valid = '1;
        #1;
        chk_res("crxor_fwd", 5'd0, 3'd1, 4'b1010);
        handshake();

        // Fill both entries: entry 0 waits on tag 20, entry 1 ready at once
        cr_value       = 32'h00C0_0000;
        cr_value_valid = 8'b0111_1111;
        cr_rs_id[0]    = 5'd20;
        disp(CR_OR, 5'd0, 5'd1, 5'd3);
        step();
        cr_value_valid = '1;
        disp(CR_ORC, 5'd8, 5'd9, 5'd10);
        #1;
        chk("fill.ready_e1", 32'(dispatch_ready), 32'd1);
        chk("fill.update_enable", 32'(update_enable), 32'h20);
        chk("fill.update_rs_id2", 32'(update_rs_id[2]), 32'd1);
        step();
        disp(CR_EQV, 5'd0, 5'd0, 5'd0);
        #1;
        chk("full.dispatch_ready", 32'(dispatch_ready), 32'd0);
        chk("full.update_enable", 32'(update_enable), 32'd0);
        chk_res("full.e1", 5'd1, 3'd2, 4'b1110);
        // Entry 0 becomes ready while entry 1 is held; selection must not move
        cdb_valid = 1'b1;
        cdb_rs_id = 5'd20;
        cdb_value = 4'b0100;
        step();
        cdb_valid = 1'b0;
        #1;
        chk_res("hold1", 5'd1, 3'd2, 4'b1110);
        chk("hold1.update_enable", 32'(update_enable), 32'd0);
        step();
        #1;
        chk_res("hold2", 5'd1, 3'd2, 4'b1110);
        step();
        #1;
        chk_res("hold3", 5'd1, 3'd2, 4'b1110);
        handshake();
        dispatch_valid = 1'b0;
        #1;
        chk("after_hs.dispatch_ready", 32'(dispatch_ready), 32'd1);
        chk_res("e0_next", 5'd0, 3'd0, 4'b0101);
        handshake();
        #1;
        chk("drained.result_valid", 32'(result_valid), 32'd0);

        // crnand ba=bb=bt=3 with field 0 = 0001
        cr_value = 32'h1000_0000;
        disp(CR_NAND, 5'd3, 5'd3, 5'd3);
        #1;
        chk("crnand.update_enable", 32'(update_enable), 32'h80);
        step();
        dispatch_valid = 1'b0;
        #1;
        chk_res("crnand", 5'd0, 3'd0, 4'b0000);
        handshake();

        // All eight operations with a=1, b=0, T=0000, target field 5 pos 0
        cr_value = 32'h00A5_0000;
        for (int i = 0; i < 8; i++) begin
            disp(ops[i], 5'd8, 5'd12, 5'd20);
            #1;
            chk($sformatf("op%0d.update_enable", i), 32'(update_enable), 32'h04);
            step();
            dispatch_valid = 1'b0;
            #1;
            chk_res($sformatf("op%0d", i), 5'd0, 3'd5, exp8[i]);
            handshake();
        end

        // Reset while a result is presented
        cr_value = 32'hC000_0000;
        disp(CR_AND, 5'd0, 5'd1, 5'd2);
        step();
        dispatch_valid = 1'b0;
        #1;
        chk("prerst.result_valid", 32'(result_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst.result_valid", 32'(result_valid), 32'd0);
        chk("midrst.dispatch_ready", 32'(dispatch_ready), 32'd1);
        chk("midrst.update_enable", 32'(update_enable), 32'd0);
        step();
        #1;
        chk("midrst.stays_empty", 32'(result_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cr_logical_rs.md
Name: cr_logical_rs

Overview:
- Reservation station and execution unit for the CR-logical instructions (crand, cror, crxor, crnand, crnor, creqv, crandc, crorc).
- Reads operand state (valid / value / RS ID) from the condition register file's read ports.
- On dispatch, claims the destination CR field through the file's update port.
- Snoops the CR result bus for pending operands and presents the finished 4-bit destination field to the CR write-back path with a valid/ready handshake.

Parameters:
RS_ID_WIDTH, 5, width of reservation-station tags; matches the condition register file.
RS_OFFSET, 0, tag of entry 0; entry k has tag RS_OFFSET+k.
NUM_ENTRIES, 2, number of station entries (1..8).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
dispatch_valid  in  1  instruction offered
dispatch_ready  out  1  at least one free entry
dispatch_op  in  cr_op_t (3)  logical operation
dispatch_ba  in  [0:4]  CR bit index, operand A
dispatch_bb  in  [0:4]  CR bit index, operand B
dispatch_bt  in  [0:4]  CR bit index, target
cr_value_valid  in  [0:7] x 1  from CR file read port
cr_value  in  [0:31]  from CR file read port
cr_rs_id  in  [0:7] x RS_ID_WIDTH  from CR file read port
update_enable  out  [0:7] x 1  to CR file update port
update_rs_id  out  [0:7] x RS_ID_WIDTH  to CR file update port
cdb_valid  in  1  CR result broadcast valid
cdb_rs_id  in  RS_ID_WIDTH  producing tag
cdb_value  in  [0:3]  produced field value
result_valid  out  1  result presented
result_ready  in  1  write-back accepts
result_rs_id  out  RS_ID_WIDTH  tag of issuing entry
result_field  out  [0:2]  destination field = bt[0:2]
result_value  out  [0:3]  new destination field value

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset: all entries free; result_valid=0; update_enable all 0; update_rs_id all 0; dispatch_ready=1 in the first cycle after reset. Reset mid-operation discards all entries and any presented result.
- Bit numbering: big-endian. CR bit n lives in field n[0:2], position n[3:4].
- Entry contents: op, bit positions for A/B/T, and three field operands (A = field of ba, B = field of bb, T = old field of bt). Each operand holds valid, tag and 4-bit value.
- Dispatch fires when dispatch_valid && dispatch_ready:
  - Allocate the lowest-index free entry.
  - Each operand captures per the CR file read port: if valid, the value; else the tag.
  - Same-cycle forwarding: if the file shows a tag equal to cdb_rs_id while cdb_valid, capture cdb_value as valid.
  - Drive update_enable[bt[0:2]]=1 and update_rs_id[bt[0:2]]=allocated tag, combinationally in the dispatch cycle. All other update_enable bits are 0.
  - Operands read the pre-update state. If A or B share the target field, they keep the old value or tag.
- Snoop: every cycle, each invalid operand whose tag equals cdb_rs_id while cdb_valid captures cdb_value and becomes valid at the clock edge.
- Ready: an entry is ready when all three operands are valid.
- Issue selection: lowest-index ready entry. The result is combinational from that entry. result_valid rises the cycle after dispatch if all operands were valid at dispatch.
- Selection lock: while result_valid && !result_ready, the selected entry and all result outputs stay stable.
- Handshake: on result_valid && result_ready the entry frees at the edge. It may be re-dispatched the following cycle. Dispatch into a different free entry is allowed in the handshake cycle.
- Compute: a = A[ba[3:4]], b = B[bb[3:4]]. r = and / or / xor / nand / nor / eqv (xnor) / andc (a&~b) / orc (a|~b). result_value = T with bit bt[3:4] replaced by r.
- Full: dispatch_ready=0 when all entries are occupied. dispatch_valid is ignored then; no update is driven.
- The station never snoops its own result. Write-back re-broadcasts it on the CDB, and waiting entries of this station match it there like any other tag.

Decomposition:
- ppc_types package gains cr_op_t (3-bit enum: CR_AND, CR_OR, CR_XOR, CR_NAND, CR_NOR, CR_EQV, CR_ANDC, CR_ORC) and cr_operand_t (struct: valid, rs_id, value[0:3]). cr_operand_t requires RS_ID_WIDTH as a package constant, default 5.
- One sub-module, cr_logical_alu: purely combinational op, A, B, T, bit positions → result_value.

Test Plan:
- Reset, then dispatch crand ba=0 bb=1 bt=2. CR=0xC000_0000, all fields valid → update_enable[0]=1, update_rs_id[0]=0 in the dispatch cycle; next cycle result_valid=1, field 0, value 4'b1110.
- Dispatch cror ba=4 bb=8 bt=12 with field 1 pending tag 7 → entry waits. cdb_valid, rs_id 7, value 4'b0000; field 2 = 4'b0000, field 3 = 4'b0000 → result field 3, value 4'b0000.
- Same-cycle forwarding: field 1 pending tag 9 and CDB broadcasts tag 9 = 4'b1000 in the dispatch cycle of crxor ba=4 bb=5 bt=6 → result 4'b1010 in the next cycle.
- Fill both entries, dispatch_valid held → dispatch_ready=0, no update_enable. Hold result_ready=0 for 3 cycles → outputs stable. Handshake → dispatch_ready=1 the next cycle.
- crnand ba=bb=bt=3 with field 0 = 4'b0001 → result 4'b0000.
- Assert rst with an entry presenting result → next cycle result_valid=0, dispatch_ready=1, update_enable all 0.
